// File: rtl/chan_reader_pkg.sv
// ----------------------------------------------------------------------------
// chan_reader_pkg
// Shared definitions for the per-channel TX packet reader: FSM state
// encoding, packet header bit positions and sample format codes.
// ----------------------------------------------------------------------------
package chan_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HEADER     = 3'd1,
        ST_TIMESTAMP  = 3'd2,
        ST_WAIT       = 3'd3,
        ST_WAITSTROBE = 3'd4,
        ST_SEND       = 3'd5,
        ST_MF_WAIT    = 3'd6
    } state_t;

    // Header word bit positions
    localparam int HDR_SOB_BIT     = 28;
    localparam int HDR_EOB_BIT     = 27;
    localparam int HDR_RSSI_BIT    = 26;
    localparam int HDR_MF_BIT      = 25;
    localparam int HDR_PAYLOAD_LSB = 2;

    // samples_format codes; anything other than QI8 is handled as QI16
    localparam logic [3:0] FMT_QI16 = 4'd0;
    localparam logic [3:0] FMT_QI8  = 4'd1;

    function automatic logic is_qi8(input logic [3:0] fmt);
        return (fmt == FMT_QI8);
    endfunction

endpackage

// File: rtl/chan_sample_unpack.sv
// ----------------------------------------------------------------------------
// chan_sample_unpack
// Combinational formatter: turns the FIFO head word into one complex sample.
// QI16 uses the low/high halfwords; QI8 picks one byte pair selected by
// i_half. The result is left-aligned into SAMPLE_W with zero LSBs.
//
// Ports:
//   i_fifodata  in  32        FIFO head word
//   i_half      in  1         QI8 half select (0 = bytes [15:0], 1 = [31:16])
//   i_qi8       in  1         1 = QI8 packed format, 0 = QI16
//   o_tx_i      out SAMPLE_W  in-phase sample
//   o_tx_q      out SAMPLE_W  quadrature sample
// ----------------------------------------------------------------------------
module chan_sample_unpack
    import chan_reader_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [31:0]         i_fifodata,
    input  logic                i_half,
    input  logic                i_qi8,
    output logic [SAMPLE_W-1:0] o_tx_i,
    output logic [SAMPLE_W-1:0] o_tx_q
);

    logic [7:0]  w_i8;
    logic [7:0]  w_q8;
    logic [15:0] w_i16;
    logic [15:0] w_q16;

    always_comb begin
        w_i8  = i_half ? i_fifodata[23:16] : i_fifodata[7:0];
        w_q8  = i_half ? i_fifodata[31:24] : i_fifodata[15:8];
        // Bytes go to the top of a 16-bit word first, so one left shift
        // aligns both formats into SAMPLE_W.
        w_i16 = i_qi8 ? {w_i8, 8'h00} : i_fifodata[15:0];
        w_q16 = i_qi8 ? {w_q8, 8'h00} : i_fifodata[31:16];
        o_tx_i = SAMPLE_W'(w_i16) << (SAMPLE_W - 16);
        o_tx_q = SAMPLE_W'(w_q16) << (SAMPLE_W - 16);
    end

endmodule

// File: rtl/chan_fifo_reader_p.sv
// ----------------------------------------------------------------------------
// chan_fifo_reader_p
// Per-channel TX packet reader. Pulls headered packets from a show-ahead
// channel FIFO, holds each until its timestamp, optionally gates on RSSI,
// then emits one complex sample per tx_strobe to the TX chain. Keeps
// wrapping counts of packets sent and dropped.
//
// Optional build macro CHAN_READER_MF_GATE_EN: adds the mf_match input and
// an MF_WAIT state that holds SOB packets carrying the MF flag until
// mf_match is seen (or the rssi_wait timeout expires).
//
// Ports:
//   tx_clock         in   1         clock
//   reset            in   1         synchronous, active-high
//   tx_strobe        in   1         sample request from TX chain
//   timestamp_clock  in   TS_W      current time
//   samples_format   in   4         0 = QI16, 1 = QI8, others = QI16
//   late_policy      in   1         0 = drop late packets, 1 = send them now
//   fifodata         in   32        FIFO head word (show-ahead)
//   pkt_waiting      in   1         complete packet available
//   rdreq            out  1         pop current head word
//   skip             out  1         pulse: discard rest of current packet
//   tx_i / tx_q      out  SAMPLE_W  output sample
//   tx_empty         out  1         output idle/zero
//   underrun         out  1         in burst with no packet waiting
//   burst            out  1         inside an SOB..EOB burst
//   rssi             in   32        current RSSI
//   threshhold       in   32        RSSI gate threshold
//   rssi_wait        in   32        RSSI/MF timeout in cycles, 0 = none
//   pkt_sent         out  CNT_W     packets fully transmitted
//   pkt_dropped      out  CNT_W     packets discarded
//   mf_match         in   1         (CHAN_READER_MF_GATE_EN only)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a complete packet, flags underrun in a burst
// HEADER      | header at FIFO head: update burst, drop or latch length
// TIMESTAMP   | timestamp at FIFO head: latch it
// WAIT        | hold until timestamp (and RSSI gate) allow sending
// WAITSTROBE  | payload ready, wait for tx_strobe or end of packet
// SEND        | present one sample, pop word when fully consumed
// MF_WAIT     | hold MF-flagged SOB packet until mf_match
// ----------------------------------------------------------------------------
module chan_fifo_reader_p
    import chan_reader_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int TS_W     = 32,
    parameter int LEN_W    = 7,
    parameter int CNT_W    = 16
) (
    input  logic                tx_clock,
    input  logic                reset,
    input  logic                tx_strobe,
    input  logic [TS_W-1:0]     timestamp_clock,
    input  logic [3:0]          samples_format,
    input  logic                late_policy,
    input  logic [31:0]         fifodata,
    input  logic                pkt_waiting,
    output logic                rdreq,
    output logic                skip,
    output logic [SAMPLE_W-1:0] tx_i,
    output logic [SAMPLE_W-1:0] tx_q,
    output logic                tx_empty,
    output logic                underrun,
    output logic                burst,
    input  logic [31:0]         rssi,
    input  logic [31:0]         threshhold,
    input  logic [31:0]         rssi_wait,
    output logic [CNT_W-1:0]    pkt_sent,
    output logic [CNT_W-1:0]    pkt_dropped
`ifdef CHAN_READER_MF_GATE_EN
    ,
    input  logic                mf_match
`endif
);

    state_t              r_state;
    logic                r_rdreq;
    logic                r_skip;
    logic [SAMPLE_W-1:0] r_tx_i;
    logic [SAMPLE_W-1:0] r_tx_q;
    logic                r_tx_empty;
    logic                r_underrun;
    logic                r_burst;
    logic                r_trash;
    logic                r_rssi_flag;
    logic                r_qi8;
    logic                r_half;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_read_len;
    logic [TS_W-1:0]     r_ts;
    logic [31:0]         r_wait_cnt;
    logic [CNT_W-1:0]    r_pkt_sent;
    logic [CNT_W-1:0]    r_pkt_dropped;
`ifdef CHAN_READER_MF_GATE_EN
    logic                r_mf_flag;
`endif

    logic [SAMPLE_W-1:0] w_smp_i;
    logic [SAMPLE_W-1:0] w_smp_q;
    logic                w_sob;
    logic                w_eob;
    logic                w_late;
    logic                w_ts_ok;
    logic                w_rssi_to;
    logic                w_rssi_ok;

    chan_sample_unpack #(
        .SAMPLE_W (SAMPLE_W)
    ) u_unpack (
        .i_fifodata (fifodata),
        .i_half     (r_half),
        .i_qi8      (r_qi8),
        .o_tx_i     (w_smp_i),
        .o_tx_q     (w_smp_q)
    );

    always_comb begin
        w_sob     = fifodata[HDR_SOB_BIT];
        w_eob     = fifodata[HDR_EOB_BIT];
        w_late    = (r_ts < timestamp_clock);
        // An all-ones timestamp means "send now"
        w_ts_ok   = (r_ts == timestamp_clock) || (&r_ts) || (w_late && late_policy);
        w_rssi_to = r_rssi_flag && (rssi_wait != 32'd0) && (r_wait_cnt >= rssi_wait);
        w_rssi_ok = !r_rssi_flag || (rssi <= threshhold);
    end

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rdreq       <= 1'b0;
            r_skip        <= 1'b0;
            r_tx_i        <= '0;
            r_tx_q        <= '0;
            r_tx_empty    <= 1'b1;
            r_underrun    <= 1'b0;
            r_burst       <= 1'b0;
            r_trash       <= 1'b0;
            r_rssi_flag   <= 1'b0;
            r_qi8         <= 1'b0;
            r_half        <= 1'b0;
            r_len         <= '0;
            r_read_len    <= '0;
            r_ts          <= '0;
            r_wait_cnt    <= '0;
            r_pkt_sent    <= '0;
            r_pkt_dropped <= '0;
`ifdef CHAN_READER_MF_GATE_EN
            r_mf_flag     <= 1'b0;
`endif
        end else begin
            if (tx_strobe && (r_state != ST_SEND))
                r_tx_empty <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_skip     <= 1'b0;
                    r_wait_cnt <= '0;
                    if (pkt_waiting) begin
                        r_state    <= ST_HEADER;
                        r_rdreq    <= 1'b1;
                        r_underrun <= 1'b0;
                    end else if (r_burst) begin
                        r_underrun <= 1'b1;
                    end
                end

                ST_HEADER: begin
                    if (w_sob && w_eob)
                        r_burst <= 1'b0;
                    else if (w_sob)
                        r_burst <= 1'b1;
                    else if (w_eob)
                        r_burst <= 1'b0;

                    // After a drop, discard packets until the next burst start
                    if (r_trash && !w_sob) begin
                        r_skip        <= 1'b1;
                        r_rdreq       <= 1'b0;
                        r_pkt_dropped <= r_pkt_dropped + 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_len       <= fifodata[LEN_W+HDR_PAYLOAD_LSB-1:HDR_PAYLOAD_LSB];
                        r_read_len  <= '0;
                        r_half      <= 1'b0;
                        r_rssi_flag <= fifodata[HDR_RSSI_BIT] && w_sob;
                        r_qi8       <= is_qi8(samples_format);
`ifdef CHAN_READER_MF_GATE_EN
                        r_mf_flag   <= fifodata[HDR_MF_BIT] && w_sob;
`endif
                        r_state     <= ST_TIMESTAMP;
                    end
                end

                ST_TIMESTAMP: begin
                    r_ts    <= TS_W'(fifodata);
                    r_rdreq <= 1'b0;
`ifdef CHAN_READER_MF_GATE_EN
                    r_state <= r_mf_flag ? ST_MF_WAIT : ST_WAIT;
`else
                    r_state <= ST_WAIT;
`endif
                end

`ifdef CHAN_READER_MF_GATE_EN
                ST_MF_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (mf_match) begin
                        // Restart the count so the RSSI timeout measures WAIT only
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end else if ((rssi_wait != 32'd0) && (r_wait_cnt >= rssi_wait)) begin
                        r_trash       <= 1'b1;
                        r_skip        <= 1'b1;
                        r_pkt_dropped <= r_pkt_dropped + 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
`endif

                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if ((w_late && !late_policy) || w_rssi_to) begin
                        r_trash       <= 1'b1;
                        r_skip        <= 1'b1;
                        r_pkt_dropped <= r_pkt_dropped + 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (w_ts_ok && w_rssi_ok) begin
                        r_trash <= 1'b0;
                        r_state <= ST_WAITSTROBE;
                    end
                end

                ST_WAITSTROBE: begin
                    if (r_read_len == r_len) begin
                        r_skip     <= 1'b1;
                        r_pkt_sent <= r_pkt_sent + 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (tx_strobe) begin
                        r_state <= ST_SEND;
                        // A QI8 word is only popped once its second half is used
                        if (!r_qi8 || r_half)
                            r_rdreq <= 1'b1;
                    end
                end

                ST_SEND: begin
                    r_tx_empty <= 1'b0;
                    r_rdreq    <= 1'b0;
                    r_tx_i     <= w_smp_i;
                    r_tx_q     <= w_smp_q;
                    if (r_qi8) begin
                        r_half <= ~r_half;
                        if (r_half)
                            r_read_len <= r_read_len + 1'b1;
                    end else begin
                        r_read_len <= r_read_len + 1'b1;
                    end
                    r_state <= ST_WAITSTROBE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdreq       = r_rdreq;
    assign skip        = r_skip;
    assign tx_i        = r_tx_i;
    assign tx_q        = r_tx_q;
    assign tx_empty    = r_tx_empty;
    assign underrun    = r_underrun;
    assign burst       = r_burst;
    assign pkt_sent    = r_pkt_sent;
    assign pkt_dropped = r_pkt_dropped;

endmodule

// File: tb/tb_chan_fifo_reader_p.sv
// ----------------------------------------------------------------------------
// tb_chan_fifo_reader_p
// Directed bench for chan_fifo_reader_p with a small show-ahead FIFO model
// that honours rdreq pops and skip (jump to end of current packet).
// ----------------------------------------------------------------------------
module tb_chan_fifo_reader_p;

    logic        tx_clock;
    logic        reset;
    logic        tx_strobe;
    logic [31:0] timestamp_clock;
    logic [3:0]  samples_format;
    logic        late_policy;
    logic [31:0] fifodata;
    logic        pkt_waiting;
    logic        rdreq;
    logic        skip;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic        tx_empty;
    logic        underrun;
    logic        burst;
    logic [31:0] rssi;
    logic [31:0] threshhold;
    logic [31:0] rssi_wait;
    logic [15:0] pkt_sent;
    logic [15:0] pkt_dropped;
`ifdef CHAN_READER_MF_GATE_EN
    logic        mf_match;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    chan_fifo_reader_p dut (
        .tx_clock        (tx_clock),
        .reset           (reset),
        .tx_strobe       (tx_strobe),
        .timestamp_clock (timestamp_clock),
        .samples_format  (samples_format),
        .late_policy     (late_policy),
        .fifodata        (fifodata),
        .pkt_waiting     (pkt_waiting),
        .rdreq           (rdreq),
        .skip            (skip),
        .tx_i            (tx_i),
        .tx_q            (tx_q),
        .tx_empty        (tx_empty),
        .underrun        (underrun),
        .burst           (burst),
        .rssi            (rssi),
        .threshhold      (threshhold),
        .rssi_wait       (rssi_wait),
        .pkt_sent        (pkt_sent),
        .pkt_dropped     (pkt_dropped)
`ifdef CHAN_READER_MF_GATE_EN
        ,
        .mf_match        (mf_match)
`endif
    );

    initial tx_clock = 1'b0;
    always #5 tx_clock = ~tx_clock;

    // ---------------- FIFO model ----------------
    logic [31:0] mem    [0:255];
    bit          is_hdr [0:255];
    int          nxt    [0:255];
    int          wr_ptr = 0;
    int          rd_ptr;
    int          cur_end;
    int          pop_cnt;

    assign fifodata    = (rd_ptr < wr_ptr) ? mem[rd_ptr] : 32'h0;
    assign pkt_waiting = (rd_ptr < wr_ptr) && is_hdr[rd_ptr] && !skip;

    always @(posedge tx_clock) begin
        if (reset) begin
            rd_ptr  <= wr_ptr;
            cur_end <= wr_ptr;
        end else if (skip) begin
            rd_ptr <= cur_end;
        end else if (rdreq && (rd_ptr < wr_ptr)) begin
            if (is_hdr[rd_ptr])
                cur_end <= nxt[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic push_pkt(input logic [31:0] hdr, input logic [31:0] ts, input int n,
                            input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        int s;
        s = wr_ptr;
        mem[s] = hdr;   is_hdr[s] = 1'b1; nxt[s] = s + 2 + n;
        mem[s+1] = ts;  is_hdr[s+1] = 1'b0;
        if (n > 0) begin mem[s+2] = p0; is_hdr[s+2] = 1'b0; end
        if (n > 1) begin mem[s+3] = p1; is_hdr[s+3] = 1'b0; end
        if (n > 2) begin mem[s+4] = p2; is_hdr[s+4] = 1'b0; end
        wr_ptr = s + 2 + n;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge tx_clock);
    endtask

    // One strobe; returns two negedges later, when the SEND result is visible
    task automatic strobe();
        tx_strobe = 1'b1;
        step(1);
        tx_strobe = 1'b0;
        step(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step(3);
        n_chk++; if (rdreq !== 1'b0)    $display("FAIL reset_rdreq got %0b exp 0", rdreq); else n_pass++;
        n_chk++; if (skip !== 1'b0)     $display("FAIL reset_skip got %0b exp 0", skip); else n_pass++;
        n_chk++; if (tx_empty !== 1'b1) $display("FAIL reset_tx_empty got %0b exp 1", tx_empty); else n_pass++;
        n_chk++; if (tx_i !== 16'h0 || tx_q !== 16'h0)
            $display("FAIL reset_txiq got %h/%h exp 0000/0000", tx_i, tx_q); else n_pass++;
        n_chk++; if (burst !== 1'b0 || underrun !== 1'b0)
            $display("FAIL reset_burst_underrun got %0b/%0b exp 0/0", burst, underrun); else n_pass++;
        n_chk++; if (pkt_sent !== 16'd0 || pkt_dropped !== 16'd0)
            $display("FAIL reset_counters got %0d/%0d exp 0/0", pkt_sent, pkt_dropped); else n_pass++;
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_qi16();
        int p0;
        samples_format  = 4'd0;
        late_policy     = 1'b0;
        timestamp_clock = 32'd90;
        p0 = pop_cnt;
        push_pkt(32'h1800000C, 32'd100, 3, 32'h22221111, 32'h44443333, 32'h66665555);
        step(10);
        n_chk++; if (tx_empty !== 1'b1 || pkt_sent !== 16'd0)
            $display("FAIL qi16_hold got empty=%0b sent=%0d exp 1/0", tx_empty, pkt_sent); else n_pass++;
        n_chk++; if (pop_cnt - p0 !== 2)
            $display("FAIL qi16_hold_pops got %0d exp 2", pop_cnt - p0); else n_pass++;
        timestamp_clock = 32'd100;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h1111 || tx_q !== 16'h2222 || tx_empty !== 1'b0)
            $display("FAIL qi16_s0 got %h/%h e=%0b exp 1111/2222 e=0", tx_i, tx_q, tx_empty); else n_pass++;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h3333 || tx_q !== 16'h4444)
            $display("FAIL qi16_s1 got %h/%h exp 3333/4444", tx_i, tx_q); else n_pass++;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h5555 || tx_q !== 16'h6666)
            $display("FAIL qi16_s2 got %h/%h exp 5555/6666", tx_i, tx_q); else n_pass++;
        step(1);
        n_chk++; if (skip !== 1'b1 || pkt_sent !== 16'd1)
            $display("FAIL qi16_done got skip=%0b sent=%0d exp 1/1", skip, pkt_sent); else n_pass++;
        step(1);
        n_chk++; if (skip !== 1'b0)
            $display("FAIL qi16_skip_pulse got %0b exp 0", skip); else n_pass++;
        n_chk++; if (pop_cnt - p0 !== 5 || burst !== 1'b0)
            $display("FAIL qi16_pops_burst got %0d/%0b exp 5/0", pop_cnt - p0, burst); else n_pass++;
        step(2);
    endtask

    task automatic test_qi8();
        int p0;
        samples_format = 4'd1;
        p0 = pop_cnt;
        push_pkt(32'h18000008, 32'hFFFFFFFF, 2, 32'h44332211, 32'h88776655, 32'h0);
        step(6);
        samples_format = 4'd0;  // must have no effect on the packet in flight
        strobe();
        n_chk++; if (tx_i !== 16'h1100 || tx_q !== 16'h2200)
            $display("FAIL qi8_s0 got %h/%h exp 1100/2200", tx_i, tx_q); else n_pass++;
        n_chk++; if (pop_cnt - p0 !== 2)
            $display("FAIL qi8_pop_s0 got %0d exp 2", pop_cnt - p0); else n_pass++;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h3300 || tx_q !== 16'h4400)
            $display("FAIL qi8_s1 got %h/%h exp 3300/4400", tx_i, tx_q); else n_pass++;
        n_chk++; if (pop_cnt - p0 !== 3)
            $display("FAIL qi8_pop_s1 got %0d exp 3", pop_cnt - p0); else n_pass++;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h5500 || tx_q !== 16'h6600)
            $display("FAIL qi8_s2 got %h/%h exp 5500/6600", tx_i, tx_q); else n_pass++;
        step(2);
        strobe();
        n_chk++; if (tx_i !== 16'h7700 || tx_q !== 16'h8800)
            $display("FAIL qi8_s3 got %h/%h exp 7700/8800", tx_i, tx_q); else n_pass++;
        n_chk++; if (pop_cnt - p0 !== 4)
            $display("FAIL qi8_pop_s3 got %0d exp 4", pop_cnt - p0); else n_pass++;
        step(1);
        n_chk++; if (skip !== 1'b1 || pkt_sent !== 16'd2)
            $display("FAIL qi8_done got skip=%0b sent=%0d exp 1/2", skip, pkt_sent); else n_pass++;
        step(2);
    endtask

    task automatic test_late();
        samples_format  = 4'd0;
        late_policy     = 1'b0;
        timestamp_clock = 32'd60;
        push_pkt(32'h10000004, 32'd50, 1, 32'hA5A5A5A5, 32'h0, 32'h0);
        push_pkt(32'h00000004, 32'hFFFFFFFF, 1, 32'h5A5A5A5A, 32'h0, 32'h0);
        step(4);
        n_chk++; if (skip !== 1'b1 || pkt_dropped !== 16'd1)
            $display("FAIL late_drop got skip=%0b dropped=%0d exp 1/1", skip, pkt_dropped); else n_pass++;
        step(6);
        n_chk++; if (pkt_dropped !== 16'd2 || rd_ptr !== wr_ptr)
            $display("FAIL late_trash got dropped=%0d rd=%0d exp 2 rd=%0d", pkt_dropped, rd_ptr, wr_ptr); else n_pass++;
        n_chk++; if (burst !== 1'b1 || underrun !== 1'b1 || pkt_sent !== 16'd2)
            $display("FAIL late_underrun got b=%0b u=%0b s=%0d exp 1/1/2", burst, underrun, pkt_sent); else n_pass++;
        late_policy = 1'b1;
        push_pkt(32'h18000004, 32'd50, 1, 32'hBBBBAAAA, 32'h0, 32'h0);
        step(6);
        strobe();
        n_chk++; if (tx_i !== 16'hAAAA || tx_q !== 16'hBBBB)
            $display("FAIL late_send got %h/%h exp AAAA/BBBB", tx_i, tx_q); else n_pass++;
        step(1);
        n_chk++; if (pkt_sent !== 16'd3 || burst !== 1'b0 || underrun !== 1'b0)
            $display("FAIL late_send_done got s=%0d b=%0b u=%0b exp 3/0/0", pkt_sent, burst, underrun); else n_pass++;
        late_policy = 1'b0;
        step(2);
    endtask

    task automatic test_burst();
        push_pkt(32'h10000000, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0);
        step(8);
        n_chk++; if (burst !== 1'b1 || underrun !== 1'b1 || pkt_sent !== 16'd4)
            $display("FAIL burst_sob got b=%0b u=%0b s=%0d exp 1/1/4", burst, underrun, pkt_sent); else n_pass++;
        push_pkt(32'h08000000, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0);
        step(8);
        n_chk++; if (burst !== 1'b0 || underrun !== 1'b0 || pkt_sent !== 16'd5)
            $display("FAIL burst_eob got b=%0b u=%0b s=%0d exp 0/0/5", burst, underrun, pkt_sent); else n_pass++;
    endtask

    task automatic test_rssi();
        rssi       = 32'd500;
        threshhold = 32'd100;
        rssi_wait  = 32'd20;
        push_pkt(32'h1C000004, 32'hFFFFFFFF, 1, 32'h0F0F0E0E, 32'h0, 32'h0);
        step(23);
        n_chk++; if (pkt_dropped !== 16'd2 || skip !== 1'b0)
            $display("FAIL rssi_early got dropped=%0d skip=%0b exp 2/0", pkt_dropped, skip); else n_pass++;
        step(1);
        n_chk++; if (pkt_dropped !== 16'd3 || skip !== 1'b1)
            $display("FAIL rssi_timeout got dropped=%0d skip=%0b exp 3/1", pkt_dropped, skip); else n_pass++;
        step(2);
        rssi = 32'd50;
        push_pkt(32'h1C000004, 32'hFFFFFFFF, 1, 32'h00770066, 32'h0, 32'h0);
        step(6);
        strobe();
        n_chk++; if (tx_i !== 16'h0066 || tx_q !== 16'h0077)
            $display("FAIL rssi_pass got %h/%h exp 0066/0077", tx_i, tx_q); else n_pass++;
        step(1);
        n_chk++; if (pkt_sent !== 16'd6 || pkt_dropped !== 16'd3)
            $display("FAIL rssi_counts got s=%0d d=%0d exp 6/3", pkt_sent, pkt_dropped); else n_pass++;
        step(2);
    endtask

    task automatic test_reset_mid_send();
        push_pkt(32'h18000008, 32'hFFFFFFFF, 2, 32'hDEADBEEF, 32'h12345678, 32'h0);
        step(6);
        tx_strobe = 1'b1;
        step(1);
        tx_strobe = 1'b0;
        reset     = 1'b1;
        step(1);
        n_chk++; if (tx_empty !== 1'b1 || tx_i !== 16'h0 || tx_q !== 16'h0)
            $display("FAIL rst_send_out got e=%0b %h/%h exp 1 0000/0000", tx_empty, tx_i, tx_q); else n_pass++;
        n_chk++; if (rdreq !== 1'b0 || skip !== 1'b0 || pkt_sent !== 16'd0 || pkt_dropped !== 16'd0)
            $display("FAIL rst_send_ctl got r=%0b k=%0b s=%0d d=%0d exp 0/0/0/0", rdreq, skip, pkt_sent, pkt_dropped); else n_pass++;
        reset = 1'b0;
        step(3);
        n_chk++; if (rdreq !== 1'b0 || tx_empty !== 1'b1 || burst !== 1'b0)
            $display("FAIL rst_send_idle got r=%0b e=%0b b=%0b exp 0/1/0", rdreq, tx_empty, burst); else n_pass++;
    endtask

    initial begin
        reset           = 1'b1;
        tx_strobe       = 1'b0;
        timestamp_clock = 32'd0;
        samples_format  = 4'd0;
        late_policy     = 1'b0;
        rssi            = 32'd0;
        threshhold      = 32'd0;
        rssi_wait       = 32'd0;
`ifdef CHAN_READER_MF_GATE_EN
        mf_match        = 1'b0;
`endif
        test_reset();
        test_qi16();
        test_qi8();
        test_late();
        test_burst();
        test_rssi();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t, %0d/%0d checks done", $time, n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/chan_fifo_reader_p.md
Name: chan_fifo_reader_p

Overview:
Parametrised per-channel TX packet reader. Pulls headered packets from a show-ahead channel FIFO, holds each until its timestamp, optionally gates on RSSI, then emits one complex sample per tx_strobe to the TX chain. Adds configurable sample width, QI8 packed format (two samples per word), a selectable late-packet policy and per-packet drop/sent counters. Sits between the channel RAM FIFO and the tx_chain.

Parameters:
SAMPLE_W, 16, width of tx_i/tx_q (>=16)
TS_W, 32, timestamp width
LEN_W, 7, payload length field width in 32-bit words
CNT_W, 16, width of the sent/drop counters

Ports:
tx_clock  in  1  clock
reset  in  1  synchronous, active-high
tx_strobe  in  1  sample request from TX chain
timestamp_clock  in  TS_W  current time
samples_format  in  4  0=QI16, 1=QI8, others treated as QI16
late_policy  in  1  0=drop late packets, 1=send late packets immediately
fifodata  in  32  FIFO head word (show-ahead)
pkt_waiting  in  1  complete packet available
rdreq  out  1  pop current head word
skip  out  1  one-cycle pulse: discard remainder of current packet
tx_i  out  SAMPLE_W  in-phase sample
tx_q  out  SAMPLE_W  quadrature sample
tx_empty  out  1  1 = output is idle/zero
underrun  out  1  set while in burst and no packet waiting
burst  out  1  inside an SOB..EOB burst
rssi  in  32  current RSSI
threshhold  in  32  RSSI gate threshold
rssi_wait  in  32  RSSI timeout in cycles, 0 = none
pkt_sent  out  CNT_W  packets fully transmitted (wraps)
pkt_dropped  out  CNT_W  packets discarded (wraps)

Behaviour:
- Reset: state IDLE; rdreq, skip, underrun, burst, tx_i, tx_q, trash, counters = 0; tx_empty = 1.
- Header: payload len = fifodata[LEN_W+1:2]; RSSI flag bit 26 (valid only with SOB); EOB bit 27; SOB bit 28; MF flag bit 25.
- IDLE: skip<=0, wait counter cleared. pkt_waiting -> HEADER, rdreq<=1, underrun<=0. burst && !pkt_waiting -> underrun<=1.
- HEADER: burst: SOB&EOB -> 0, SOB -> 1, EOB -> 0. trash && !SOB -> skip<=1, rdreq<=0, pkt_dropped++, IDLE. Otherwise latch len, read_len<=0, half<=0, -> TIMESTAMP.
- TIMESTAMP: latch timestamp, rdreq<=0, -> WAIT (or MF_WAIT, see feature).
- WAIT: wait counter increments each cycle.
  - ts < clock and late_policy=0, or RSSI timeout (rssi_flag && rssi_wait!=0 && counter>=rssi_wait): trash<=1, skip<=1, pkt_dropped++, IDLE.
  - ts == clock, ts all-ones, or (ts < clock and late_policy=1): if !rssi_flag or rssi<=threshhold -> trash<=0, WAITSTROBE; else stay.
  - Timeout check has priority over send.
- WAITSTROBE: read_len==len -> skip<=1, pkt_sent++, IDLE. Else on tx_strobe -> SEND; rdreq<=1 only when QI16 or half==1 (last half of QI8 word).
- SEND (one cycle): tx_empty<=0, rdreq<=0, -> WAITSTROBE.
  - QI16: tx_i=fifodata[15:0], tx_q=[31:16], each left-aligned into SAMPLE_W (low bits zero); read_len++.
  - QI8: half 0 uses I=[7:0], Q=[15:8]; half 1 uses I=[23:16], Q=[31:24]; byte placed in MSBs of SAMPLE_W; read_len++ only after half 1; half toggles.
- Zero-length packet: WAITSTROBE exits on first cycle, counted as sent.
- While not in SEND, any tx_strobe forces tx_empty<=1.
- samples_format is sampled at HEADER and held for the packet.
- Reset mid-packet returns to IDLE immediately. No skip is issued; the FIFO owner flushes.
- Counters wrap at 2^CNT_W.

Optional Feature:
CHAN_READER_MF_GATE_EN. With it: adds input mf_match (1 bit). A packet with SOB and MF flag goes TIMESTAMP -> MF_WAIT; MF_WAIT -> WAIT when mf_match=1, and -> IDLE with drop and trash<=1 if the wait counter reaches rssi_wait (nonzero). Without it: no mf_match port, MF flag ignored, TIMESTAMP always -> WAIT.

Decomposition:
- Package chan_reader_pkg: state enum; header bit constants (SOB, EOB, RSSI, MF, PAYLOAD lsb); format codes QI16/QI8.
- Sub-module chan_sample_unpack: combinational, formats fifodata/half/format into tx_i/tx_q.

Test Plan:
- QI16, len=3, ts=100, clock reaches 100, strobe every 4 cycles -> 3 samples out, tx_i=0x1111 from 0x22221111, skip pulse, pkt_sent=1.
- QI8, len=2, word 0x44332211 -> (I,Q)=(0x1100,0x2200) then (0x3300,0x4400); 2 rdreq pops for 4 strobes.
- ts=50, clock=60, late_policy=0 -> skip, pkt_dropped=1; next non-SOB packet skipped in HEADER (pkt_dropped=2); late_policy=1 -> packet sent immediately.
- RSSI flag, rssi=500 > threshhold=100, rssi_wait=20 -> dropped after 20 WAIT cycles; with rssi=50 -> sent.
- SOB packet then pkt_waiting low -> burst=1, underrun=1; EOB packet -> burst=0.
- Reset asserted during SEND -> next cycle IDLE, tx_empty=1, outputs zero.
